// File: rtl/cam_lookup_ctrl.sv
// CAM lookup initiator: searches each requested key, allocates a round-robin entry on a miss,
// and returns hit/miss plus the entry index over a valid/ready handshake.
module cam_lookup_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_key_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_hit_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic                  cam_search_o,
  output logic [DATA_WIDTH-1:0] cam_search_data_o,
  input  logic                  cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
  output logic                  cam_write_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [DATA_WIDTH-1:0] cam_write_data_o,
  output logic [CNT_WIDTH-1:0]  hit_count_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSearch = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StAlloc  = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    ptr_d      = ptr_q;
    hit_d      = hit_q;
    idx_d      = idx_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          key_d   = req_key_i;
          state_d = StSearch;
        end
      end
      StSearch: state_d = StWait;
      StWait: begin
        if (cam_search_valid_i) begin
          hit_d = 1'b1;
          idx_d = cam_search_index_i;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
          state_d = StResp;
        end else begin
          state_d = StAlloc;
        end
      end
      StAlloc: begin
        hit_d = 1'b0;
        idx_d = ptr_q;
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        // Explicit wrap keeps non-power-of-two depths correct.
        ptr_d   = (ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : ptr_q + ADDR_WIDTH'(1);
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      key_q      <= '0;
      ptr_q      <= '0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      ptr_q      <= ptr_d;
      hit_q      <= hit_d;
      idx_q      <= idx_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    req_ready_o       = (state_q == StIdle);
    rsp_valid_o       = (state_q == StResp);
    rsp_hit_o         = hit_q;
    rsp_index_o       = idx_q;
    cam_search_o      = (state_q == StSearch);
    cam_search_data_o = key_q;
    cam_write_o       = (state_q == StAlloc);
    cam_write_index_o = ptr_q;
    cam_write_data_o  = key_q;
    hit_count_o       = hit_cnt_q;
    miss_count_o      = miss_cnt_q;
  end

endmodule

// File: doc/cam_lookup_ctrl.md
Name: cam_lookup_ctrl

Overview:
- Initiator side of the CAM read/write/search interface.
- Accepts a stream of lookup keys and issues a CAM search for each key.
- On a miss, allocates a CAM entry with round-robin replacement (CAM write of the key). Returns hit/miss plus the entry index to the requester over a valid/ready handshake.
- Sits between the requesting datapath and the CAM. Keeps saturating hit and miss counters.

Parameters:
- DATA_WIDTH, 32, key/entry width; must match the CAM.
- ADDR_WIDTH, 5, CAM index width.
- DEPTH, 1<<ADDR_WIDTH, number of CAM entries.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  lookup request valid.
- req_ready_o  out  1  controller can accept a request.
- req_key_i  in  DATA_WIDTH  key to look up.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  requester accepts the response.
- rsp_hit_o  out  1  1 = key was present; 0 = key was newly allocated.
- rsp_index_o  out  ADDR_WIDTH  CAM index of the hit or of the allocated entry.
- cam_search_o  out  1  search strobe to the CAM.
- cam_search_data_o  out  DATA_WIDTH  search key.
- cam_search_valid_i  in  1  CAM match flag, valid the cycle after cam_search_o.
- cam_search_index_i  in  ADDR_WIDTH  CAM match index, valid with cam_search_valid_i.
- cam_write_o  out  1  write strobe to the CAM.
- cam_write_index_o  out  ADDR_WIDTH  write index.
- cam_write_data_o  out  DATA_WIDTH  write data.
- hit_count_o  out  CNT_WIDTH  saturating hit count.
- miss_count_o  out  CNT_WIDTH  saturating miss count.

Behaviour:
- Reset (rst_i high at a clock edge, in any state):
  - State goes to IDLE; all outputs go to 0 except req_ready_o.
  - req_ready_o = 1 from the first cycle after reset deasserts.
  - Allocation pointer = 0; both counters = 0; the registered key is cleared.
- States: IDLE, SEARCH, WAIT, ALLOC, RESP.
- IDLE:
  - req_ready_o = 1 only in IDLE.
  - When req_valid_i & req_ready_o, register req_key_i and go to SEARCH.
- SEARCH (exactly 1 cycle):
  - cam_search_o = 1 and cam_search_data_o = registered key.
  - Go to WAIT.
- WAIT (exactly 1 cycle):
  - Sample cam_search_valid_i / cam_search_index_i.
  - Match: set rsp_hit = 1, rsp_index = cam_search_index_i, increment hit counter, go to RESP.
  - No match: go to ALLOC.
- ALLOC (exactly 1 cycle):
  - cam_write_o = 1, cam_write_index_o = pointer, cam_write_data_o = key.
  - Set rsp_hit = 0, rsp_index = pointer, increment miss counter.
  - Pointer = (pointer+1) mod DEPTH, so DEPTH-1 wraps to 0. Go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_hit_o and rsp_index_o are held stable until rsp_ready_i = 1.
  - On rsp_valid_o & rsp_ready_i, go to IDLE.
- Latency, counting the accept edge as cycle 0:
  - Hit: rsp_valid_o asserted in cycle 3.
  - Miss: rsp_valid_o asserted in cycle 4.
  - Minimum request-to-request spacing is 4 cycles (hit) or 5 cycles (miss) with rsp_ready_i tied high.
- Outside their states, the strobes cam_search_o and cam_write_o are 0. cam_*_data/index outputs are don't-care when their strobe is low; the bench must not check them then.
- Counters saturate at all-ones and never wrap. Each counter increments at most once per request.
- Replacement is pure round-robin: entries are overwritten regardless of content. No duplicate key is written because allocation only follows a miss.
- Reset during ALLOC:
  - The write strobe is not asserted in the cycle after reset.
  - If the reset edge coincides with the ALLOC cycle, the CAM write issued in that cycle stands. The pointer and miss counter are still cleared.
- A response pending in RESP is discarded by reset.
- req_key_i changes while not in IDLE are ignored.

Test Plan:
- Empty CAM model (all entries invalid), key 0xDEADBEEF:
  - Expect cam_search_o in cycle 1 and cam_write_o in cycle 3 with index 0 and data 0xDEADBEEF.
  - Expect rsp_valid_o in cycle 4 with hit=0, index=0, miss_count_o=1.
- Re-request 0xDEADBEEF → rsp_valid_o in cycle 3 with hit=1, index=0, hit_count_o=1, no cam_write_o.
- 33 distinct keys 0x100..0x120 on an empty CAM:
  - Indices returned are 0..31, then 0 for key 0x120, which overwrites 0x100.
  - A subsequent lookup of 0x100 misses and allocates index 1.
- Backpressure: hold rsp_ready_i=0 for 10 cycles → rsp_valid_o/rsp_hit_o/rsp_index_o stable and req_ready_o=0 throughout. Release → one handshake, then IDLE with req_ready_o=1.
- Assert rst_i in the WAIT cycle of a miss → no cam_write_o afterwards, pointer 0, counters 0, rsp_valid_o never asserted. The next miss allocates index 0.
- CNT_WIDTH=2, 5 consecutive hits → hit_count_o reads 1,2,3,3,3.
